layer_stream_collector: RTL and testbench
=========================================

// Module: layer_stream_collector
// PURPOSE
//  Serial-to-parallel collector for inter-layer activation streams. Accepts one DATA_WIDTH word
//  per in_valid cycle and packs NEURON_NUM consecutive words into one flat vector. Emits the
//  vector with a 1-cycle out_valid pulse. Sits between a layer's serialized output stream and
//  any consumer that needs the whole activation vector at once (maxfinder, debug capture, next-layer RAM).
// PARAMETERS
//  NEURON_NUM      10   words per frame (>=2)
//  DATA_WIDTH      16   bits per word
//  CNT_WIDTH       16   width of word and frame counters
//  TIMEOUT_CYCLES  64   idle gap that aborts a partial frame (used only with FRAME_TIMEOUT_EN)
// PORTS
//  clk        in   1                      rising-edge clock
//  rst        in   1                      synchronous, active-high reset
//  in_data    in   DATA_WIDTH             stream word
//  in_valid   in   1                      in_data is valid this cycle; no backpressure
//  out_data   out  NEURON_NUM*DATA_WIDTH  packed frame; word k at [k*DATA_WIDTH +: DATA_WIDTH]
//  out_valid  out  1                      1-cycle pulse: out_data holds a new complete frame
//  frame_cnt  out  CNT_WIDTH              completed frames since reset, wraps at 2^CNT_WIDTH
//  frame_err  out  1                      1-cycle pulse: partial frame discarded
// BEHAVIOUR
//  - Single clock domain (clk). rst is synchronous and active-high. All state is sampled on the clk rising edge.
//  - Reset: state=IDLE, word_cnt=0, assembly reg=0, out_data=0, out_valid=0, frame_cnt=0, frame_err=0.
//  - First word of a frame goes to word 0 (LSB). Word k goes to bits [k*DATA_WIDTH +: DATA_WIDTH].
//  - FSM, 2 states:
//    IDLE:    in_valid -> store word 0, word_cnt=1, go COLLECT.
//    COLLECT: in_valid -> store word at index word_cnt, word_cnt++.
//             On the NEURON_NUM-th word: copy the full assembly to out_data and pulse out_valid,
//             increment frame_cnt, set word_cnt=0, go IDLE.
//             !in_valid -> hold state (gaps allowed mid-frame).
//  - Latency: out_valid is high in the cycle after the clock edge that samples the last word.
//    out_data is valid in that same cycle.
//  - out_data is a shadow register. It changes only at frame completion and stays stable until the
//    next completed frame. The assembly register is separate.
//  - Back-to-back frames: word 0 of frame N+1 may arrive in the cycle right after the last word
//    of frame N. It is accepted with no dropped word. out_valid for frame N still pulses once.
//  - Assembly slots not yet written in the current frame are don't-care internally. They never
//    reach out_data, because only complete frames are copied.
//  - rst mid-frame: the partial frame is discarded. No out_valid or frame_err pulse.
//  - frame_cnt wraps from 2^CNT_WIDTH-1 to 0 with no flag.
// CONFIGURATION
//  Macro FRAME_TIMEOUT_EN:
//   defined: a gap counter resets on every in_valid while in COLLECT and increments otherwise.
//     When it reaches TIMEOUT_CYCLES, the partial frame is dropped: frame_err pulses 1 cycle,
//     word_cnt=0, state goes IDLE. out_data and frame_cnt are unchanged.
//     If in_valid coincides with the timeout cycle, the word is accepted and no timeout occurs.
//   undefined: no gap counter. frame_err is tied 0. A partial frame waits indefinitely.
// TESTING
//  T1 reset: hold rst 3 cycles with in_valid toggling -> out_valid=0, frame_err=0, out_data=0, frame_cnt=0.
//  T2 single frame, NEURON_NUM=10: words 0x0001..0x000A on 10 consecutive cycles
//     -> one out_valid pulse 1 cycle after word 10; out_data[15:0]=0x0001, out_data[159:144]=0x000A; frame_cnt=1.
//  T3 gapped frame: 10 words with random 0-5 cycle gaps -> same out_data as T2,
//     exactly one out_valid, no frame_err.
//  T4 back-to-back: 3 frames of 30 consecutive words (0x0100+i) -> 3 out_valid pulses 10 cycles apart;
//     out_data stable between pulses; frame_cnt=3.
//  T5 reset mid-frame: 4 words, rst 1 cycle, then a full frame of 0x00AA
//     -> one out_valid; every word of out_data = 0x00AA.
//  T6 timeout (FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=64): 5 words then 64 idle cycles
//     -> frame_err pulses once, no out_valid. A following full frame completes normally.
//     Without the macro, the same stimulus gives frame_err=0 and the next 5 words complete the frame.

Source files
------------

// File: rtl/layer_stream_collector.sv
// Serial-to-parallel collector: packs NEURON_NUM stream words into one flat frame vector.
// Optional macro FRAME_TIMEOUT_EN adds an idle-gap timeout that discards partial frames.
module layer_stream_collector #(
   parameter int NEURON_NUM     = 10,
   parameter int DATA_WIDTH     = 16,
   parameter int CNT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_WIDTH-1:0]            in_data,
   input  logic                             in_valid,
   output logic [NEURON_NUM*DATA_WIDTH-1:0] out_data,
   output logic                             out_valid,
   output logic [CNT_WIDTH-1:0]             frame_cnt,
   output logic                             frame_err
);

   localparam int FRAME_W = NEURON_NUM * DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NEURON_NUM - 1);

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
   logic [FRAME_W-1:0]   assembly_q, assembly_d;
   logic                 frame_done;
   logic                 timeout;

`ifdef FRAME_TIMEOUT_EN
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);
   logic [GAP_W-1:0] gap_q;
`endif

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      assembly_d = assembly_q;
      frame_done = 1'b0;
      timeout    = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               assembly_d[0 +: DATA_WIDTH] = in_data;
               word_cnt_d = CNT_WIDTH'(1);
               state_d    = COLLECT;
            end
         end
         COLLECT: begin
            if (in_valid) begin
               // Constant-index slot select keeps the write a plain decoder.
               for (int k = 0; k < NEURON_NUM; k++) begin
                  if (word_cnt_q == CNT_WIDTH'(k)) begin
                     assembly_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                  end
               end
               if (word_cnt_q == LAST_IDX) begin
                  frame_done = 1'b1;
                  word_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end
`ifdef FRAME_TIMEOUT_EN
            else if (gap_q == GAP_LAST) begin
               timeout    = 1'b1;
               word_cnt_d = '0;
               state_d    = IDLE;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         // NOTE: the assembly register is reset even though unwritten slots are don't-care,
         // so it never carries X into simulation or equivalence checks.
         assembly_q <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         assembly_q <= assembly_d;
         out_valid  <= frame_done;
         if (frame_done) begin
            out_data  <= assembly_d;
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

`ifdef FRAME_TIMEOUT_EN
   // Gap counter runs only while a partial frame is waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_q     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= timeout;
         if (state_q != COLLECT || in_valid || timeout) begin
            gap_q <= '0;
         end else begin
            gap_q <= gap_q + 1'b1;
         end
      end
   end
`else
   assign frame_err = timeout;
`endif

endmodule

// File: tb/tb_layer_stream_collector.sv
// Self-checking bench for layer_stream_collector: queue-based frame model plus directed tests.
// Honours FRAME_TIMEOUT_EN the same way as the design for the timeout test.
module tb_layer_stream_collector;

   localparam int NN  = 10;
   localparam int DW  = 16;
   localparam int CW  = 16;
   localparam int TO  = 64;
   localparam int W   = NN * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic [CW-1:0] frame_cnt;
   logic          frame_err;

   layer_stream_collector #(
      .NEURON_NUM(NN), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .frame_cnt(frame_cnt), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a frame is simply the list of accepted words; it is emitted once NN have arrived.
   logic [DW-1:0] cur[$];
   logic [W-1:0]  m_data = '0;
   logic          m_valid = 1'b0;
   logic          m_err = 1'b0;
   logic [CW-1:0] m_cnt = '0;
   int            m_idle = 0;
   bit            model_ok = 0;
   int            cyc = 0;

   always @(posedge clk) begin
      cyc++;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (rst) begin
         cur.delete();
         m_data   = '0;
         m_cnt    = '0;
         m_idle   = 0;
         model_ok = 1;
      end else if (in_valid) begin
         cur.push_back(in_data);
         m_idle = 0;
         if (cur.size() == NN) begin
            for (int k = 0; k < NN; k++) m_data[k*DW +: DW] = cur[k];
            m_valid = 1'b1;
            m_cnt   = m_cnt + 1'b1;
            cur.delete();
         end
      end else if (cur.size() > 0) begin
         m_idle++;
`ifdef FRAME_TIMEOUT_EN
         if (m_idle == TO) begin
            cur.delete();
            m_err  = 1'b1;
            m_idle = 0;
         end
`endif
      end
   end

   int pulses = 0;
   int errs = 0;
   int pulse_cyc[$];

   always @(negedge clk) begin
      if (model_ok) begin
         check("out_valid", W'(out_valid), W'(m_valid));
         check("frame_err", W'(frame_err), W'(m_err));
         check("frame_cnt", W'(frame_cnt), W'(m_cnt));
         check("out_data", out_data, m_data);
         if (out_valid) begin
            pulses++;
            pulse_cyc.push_back(cyc);
         end
         if (frame_err) errs++;
      end
   end

   task automatic send(input logic [DW-1:0] d);
      in_data  = d;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic gap(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [W-1:0] t2_exp;
   int gaps[9] = '{0, 3, 5, 1, 2, 0, 4, 5, 1};
   int p0, e0;
   logic [CW-1:0] c0;

   initial begin
      for (int k = 0; k < NN; k++) t2_exp[k*DW +: DW] = DW'(k + 1);

      // T1: reset held 3 cycles with in_valid toggling
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data  = DW'(16'h5500 + i);
         in_valid = (i % 2 == 0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check("t1_out_valid", W'(out_valid), '0);
      check("t1_frame_err", W'(frame_err), '0);
      check("t1_out_data", out_data, '0);
      check("t1_frame_cnt", W'(frame_cnt), '0);
      rst = 1'b0;
      gap(2);

      // T2: one frame of consecutive words
      for (int i = 1; i <= NN; i++) send(DW'(i));
      check("t2_out_valid", W'(out_valid), W'(1'b1));
      check("t2_word0", W'(out_data[15:0]), W'(16'h0001));
      check("t2_word9", W'(out_data[159:144]), W'(16'h000A));
      check("t2_frame_cnt", W'(frame_cnt), W'(16'd1));
      gap(3);

      // T3: same frame with gaps between words
      p0 = pulses; e0 = errs;
      for (int i = 1; i <= NN; i++) begin
         send(DW'(i));
         if (i < NN) gap(gaps[i-1]);
      end
      gap(2);
      check("t3_pulses", W'(pulses - p0), W'(1));
      check("t3_errs", W'(errs - e0), W'(0));
      check("t3_out_data", out_data, t2_exp);

      // T4: three back-to-back frames
      p0 = pulses; c0 = frame_cnt;
      pulse_cyc.delete();
      for (int i = 0; i < 3 * NN; i++) send(DW'(16'h0100 + i));
      gap(3);
      check("t4_pulses", W'(pulses - p0), W'(3));
      check("t4_frame_cnt_delta", W'(frame_cnt - c0), W'(3));
      if (pulse_cyc.size() == 3) begin
         check("t4_spacing_a", W'(pulse_cyc[1] - pulse_cyc[0]), W'(NN));
         check("t4_spacing_b", W'(pulse_cyc[2] - pulse_cyc[1]), W'(NN));
      end else begin
         check("t4_pulse_list", W'(pulse_cyc.size()), W'(3));
      end
      check("t4_last_word", W'(out_data[159:144]), W'(16'h011D));

      // T5: reset mid-frame, then a full frame of 0x00AA
      for (int i = 0; i < 4; i++) send(DW'(16'h0700 + i));
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      p0 = pulses; e0 = errs;
      for (int i = 0; i < NN; i++) send(16'h00AA);
      gap(2);
      check("t5_pulses", W'(pulses - p0), W'(1));
      check("t5_errs", W'(errs - e0), W'(0));
      check("t5_frame_cnt", W'(frame_cnt), W'(16'd1));
      for (int k = 0; k < NN; k++) check("t5_word", W'(out_data[k*DW +: DW]), W'(16'h00AA));

      // T6: partial frame followed by a long idle gap
      p0 = pulses; e0 = errs; c0 = frame_cnt;
      for (int i = 0; i < 5; i++) send(DW'(16'h0300 + i));
      gap(TO);
`ifdef FRAME_TIMEOUT_EN
      gap(2);
      check("t6_err_pulse", W'(errs - e0), W'(1));
      check("t6_no_valid", W'(pulses - p0), W'(0));
      for (int i = 0; i < NN; i++) send(DW'(16'h0400 + i));
      gap(2);
      check("t6_next_frame", W'(pulses - p0), W'(1));
      check("t6_frame_cnt", W'(frame_cnt - c0), W'(1));
      check("t6_word0", W'(out_data[15:0]), W'(16'h0400));
`else
      check("t6_no_err", W'(errs - e0), W'(0));
      check("t6_no_valid", W'(pulses - p0), W'(0));
      for (int i = 5; i < NN; i++) send(DW'(16'h0300 + i));
      gap(2);
      check("t6_completed", W'(pulses - p0), W'(1));
      check("t6_word0", W'(out_data[15:0]), W'(16'h0300));
      check("t6_word9", W'(out_data[159:144]), W'(16'h0309));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
